// File: rtl/exec_pkg.sv
// Shared execution-stage types: the writeback entry carried from the ALU
// units through the per-unit buffers onto the writeback bus.
package exec_pkg;

  localparam int BITWIDTH = 32;
  localparam int RF_DEPTH = 32;
  localparam int RD_W     = $clog2(RF_DEPTH);

  typedef struct packed {
    logic [BITWIDTH-1:0] result;
    logic [RD_W-1:0]     rd;
  } wb_entry_t;

  // Index width that stays legal (>= 1 bit) even for a single-element range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small register FIFO holding writeback entries for one ALU unit.
// A push into a full FIFO is refused even if a pop happens in the same cycle,
// matching the count-based ready seen by the producer. Flush empties it.
module wb_fifo
  import exec_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer advance with explicit wrap so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == CNT_W'(0));
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Read/write pointers and occupancy; flush discards everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else if (flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; cleared on reset so no stale data is ever observable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Writeback arbiter: buffers ALU results per unit and broadcasts one result
// per cycle on the registered writeback bus, granting units round-robin.
// Results targeting register 0 complete their handshake but are discarded.
module cdb_writeback_arbiter
  import exec_pkg::*;
#(
  parameter int NRALUOP   = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             Flush,
  input  logic [NRALUOP-1:0]               ALUValid,
  input  logic [NRALUOP-1:0][BITWIDTH-1:0] ALUResult,
  input  logic [NRALUOP-1:0][RD_W-1:0]     ALURd,
  output logic [NRALUOP-1:0]               ALUReady,
  output logic [BITWIDTH-1:0]              ResultW,
  output logic [RD_W-1:0]                  RdW,
  output logic                             RegWriteW
);

  localparam int IDX_W = idx_width(NRALUOP);
  localparam int SUM_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NRALUOP - 1);
  localparam logic [SUM_W-1:0] N_UNITS_S = SUM_W'(NRALUOP);

  logic [NRALUOP-1:0]   full_s;
  logic [NRALUOP-1:0]   empty_s;
  logic [NRALUOP-1:0]   nonempty_s;
  logic [NRALUOP-1:0]   push_s;
  logic [NRALUOP-1:0]   pop_s;
  wb_entry_t            din_s  [NRALUOP];
  wb_entry_t            head_s [NRALUOP];

  logic [2*NRALUOP-1:0] doubled_s;
  logic [NRALUOP-1:0]   rotated_s;
  logic [IDX_W-1:0]     offset_s;
  logic [SUM_W-1:0]     sum_s;
  logic [IDX_W-1:0]     grant_s;
  logic [IDX_W-1:0]     next_ptr_s;
  logic                 any_s;
  wb_entry_t            sel_entry_s;

  logic [IDX_W-1:0]     rr_ptr_r;

  assign ALUReady   = ~full_s;
  assign nonempty_s = ~empty_s;

  // Per-unit push/pop qualification; Rd=0 results are acknowledged but dropped.
  always_comb begin
    for (int i = 0; i < NRALUOP; i++) begin
      din_s[i]  = '{result: ALUResult[i], rd: ALURd[i]};
      push_s[i] = ALUValid[i] && !full_s[i] && (ALURd[i] != RD_W'(0));
      pop_s[i]  = any_s && !Flush && (grant_s == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < NRALUOP; g++) begin : g_unit
    wb_fifo #(
      .DEPTH(BUF_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(Flush),
      .push (push_s[g]),
      .pop  (pop_s[g]),
      .din  (din_s[g]),
      .head (head_s[g]),
      .full (full_s[g]),
      .empty(empty_s[g])
    );
  end

  // Round-robin grant: rotate the non-empty vector so rr_ptr sits at bit 0,
  // pick the lowest set bit, then map the offset back to a unit index.
  always_comb begin
    doubled_s = {nonempty_s, nonempty_s} >> rr_ptr_r;
    rotated_s = doubled_s[NRALUOP-1:0];
    offset_s  = IDX_W'(0);
    for (int i = NRALUOP - 1; i >= 0; i--) begin
      offset_s = rotated_s[i] ? IDX_W'(i) : offset_s;
    end
    any_s      = |nonempty_s;
    sum_s      = {1'b0, rr_ptr_r} + {1'b0, offset_s};
    grant_s    = (sum_s >= N_UNITS_S) ? IDX_W'(sum_s - N_UNITS_S) : IDX_W'(sum_s);
    next_ptr_s = (grant_s == LAST_IDX) ? IDX_W'(0) : grant_s + IDX_W'(1);
    sel_entry_s = head_s[grant_s];
  end

  // Writeback bus register and round-robin pointer; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ResultW   <= BITWIDTH'(0);
      RdW       <= RD_W'(0);
      RegWriteW <= 1'b0;
      rr_ptr_r  <= IDX_W'(0);
    end else if (Flush) begin
      ResultW   <= ResultW;
      RdW       <= RdW;
      RegWriteW <= 1'b0;
      rr_ptr_r  <= IDX_W'(0);
    end else if (any_s) begin
      ResultW   <= sel_entry_s.result;
      RdW       <= sel_entry_s.rd;
      RegWriteW <= 1'b1;
      rr_ptr_r  <= next_ptr_s;
    end else begin
      ResultW   <= ResultW;
      RdW       <= RdW;
      RegWriteW <= 1'b0;
      rr_ptr_r  <= rr_ptr_r;
    end
  end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Self-checking bench for cdb_writeback_arbiter: a queue-based model of the
// per-unit buffers and round-robin grant, compared every cycle, plus directed
// scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_cdb_writeback_arbiter;
  import exec_pkg::*;

  localparam int NU    = 8;
  localparam int DEPTH = 2;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        Flush = 1'b0;
  logic [NU-1:0]               ALUValid = '0;
  logic [NU-1:0][BITWIDTH-1:0] ALUResult = '0;
  logic [NU-1:0][RD_W-1:0]     ALURd = '0;
  logic [NU-1:0]               ALUReady;
  logic [BITWIDTH-1:0]         ResultW;
  logic [RD_W-1:0]             RdW;
  logic                        RegWriteW;

  cdb_writeback_arbiter #(.NRALUOP(NU), .BUF_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Flush    (Flush),
    .ALUValid (ALUValid),
    .ALUResult(ALUResult),
    .ALURd    (ALURd),
    .ALUReady (ALUReady),
    .ResultW  (ResultW),
    .RdW      (RdW),
    .RegWriteW(RegWriteW)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;
  bit log_en   = 1'b0;
  logic [RD_W-1:0] bus_rd_log [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per unit, a round-robin start index and the
  // expected bus contents after each edge.
  wb_entry_t           q [NU][$];
  int                  rr = 0;
  logic [BITWIDTH-1:0] m_res = '0;
  logic [RD_W-1:0]     m_rd = '0;
  logic                m_we = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    bit rdy [NU];
    wb_entry_t e;
    if (!rst_n) begin
      for (int i = 0; i < NU; i++) q[i].delete();
      rr = 0; m_res = '0; m_rd = '0; m_we = 1'b0;
    end else if (Flush) begin
      for (int i = 0; i < NU; i++) q[i].delete();
      rr = 0; m_we = 1'b0;
    end else begin
      for (int i = 0; i < NU; i++) rdy[i] = (q[i].size() < DEPTH);
      g = -1;
      for (int k = 0; k < NU; k++) begin
        int j;
        j = (rr + k) % NU;
        if (g < 0 && q[j].size() > 0) g = j;
      end
      if (g >= 0) begin
        e = q[g].pop_front();
        m_res = e.result; m_rd = e.rd; m_we = 1'b1;
        rr = (g + 1) % NU;
      end else begin
        m_we = 1'b0;
      end
      for (int i = 0; i < NU; i++) begin
        if (ALUValid[i] && rdy[i] && ALURd[i] != '0) begin
          e.result = ALUResult[i]; e.rd = ALURd[i];
          q[i].push_back(e);
        end
      end
    end
  end

  // Compare process: DUT against model on every falling edge out of reset.
  always @(negedge clk) begin
    logic [NU-1:0] exp_rdy;
    if (rst_n && check_en) begin
      for (int i = 0; i < NU; i++) exp_rdy[i] = (q[i].size() < DEPTH);
      check("model_RegWriteW", 64'(RegWriteW), 64'(m_we));
      check("model_ResultW", 64'(ResultW), 64'(m_res));
      check("model_RdW", 64'(RdW), 64'(m_rd));
      check("model_ALUReady", 64'(ALUReady), 64'(exp_rdy));
      if (RegWriteW && log_en) bus_rd_log.push_back(RdW);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ALUValid = '0;
    Flush    = 1'b0;
  endtask

  task automatic flush_cycle();
    idle();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
  endtask

  initial begin
    int w;
    int seen;
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_RegWriteW", 64'(RegWriteW), 64'd0);
    check("reset_ResultW", 64'(ResultW), 64'd0);
    check("reset_RdW", 64'(RdW), 64'd0);
    rst_n = 1'b1;
    check_en = 1'b1;
    step();
    check("reset_ALUReady", 64'(ALUReady), 64'hFF);

    // Single result from unit 3
    ALUValid[3] = 1'b1; ALUResult[3] = 32'hDEADBEEF; ALURd[3] = 5'd5;
    step();
    idle();
    check("single_no_bypass", 64'(RegWriteW), 64'd0);
    step();
    check("single_ResultW", 64'(ResultW), 64'hDEADBEEF);
    check("single_RdW", 64'(RdW), 64'd5);
    check("single_RegWriteW", 64'(RegWriteW), 64'd1);
    step();
    check("single_pulse_end", 64'(RegWriteW), 64'd0);

    // Fairness: all units at once from rr_ptr = 0
    flush_cycle();
    for (int i = 0; i < NU; i++) begin
      ALUResult[i] = BITWIDTH'(i); ALURd[i] = RD_W'(i + 1);
    end
    ALUValid = '1;
    step();
    idle();
    for (int i = 0; i < NU; i++) begin
      step();
      check("fair_RegWriteW", 64'(RegWriteW), 64'd1);
      check("fair_ResultW", 64'(ResultW), 64'(i));
      check("fair_RdW", 64'(RdW), 64'(i + 1));
    end
    step();
    check("fair_idle", 64'(RegWriteW), 64'd0);
    ALUValid[0] = 1'b1; ALURd[0] = 5'd9;
    ALUValid[5] = 1'b1; ALURd[5] = 5'd14;
    step();
    idle();
    step();
    check("wrap_first_unit0", 64'(RdW), 64'd9);
    step();
    check("wrap_then_unit5", 64'(RdW), 64'd14);

    // Backpressure on unit 2 while units 0 and 1 stay busy
    flush_cycle();
    bus_rd_log.delete();
    log_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      ALUValid[2] = 1'b1; ALUResult[2] = BITWIDTH'(32'hB0 + j); ALURd[2] = RD_W'(10 + j);
      w = 0;
      while (!ALUReady[2] && w < 20) begin
        for (int u = 0; u < 2; u++) begin
          ALUValid[u] = 1'b1; ALUResult[u] = $urandom; ALURd[u] = RD_W'($urandom_range(20, 31));
        end
        step();
        w++;
      end
      check("bp_wait_bound", 64'(w < 20), 64'd1);
      for (int u = 0; u < 2; u++) begin
        ALUValid[u] = 1'b1; ALUResult[u] = $urandom; ALURd[u] = RD_W'($urandom_range(20, 31));
      end
      step();
      if (j == 1) check("bp_ready_low_after_two", 64'(ALUReady[2]), 64'd0);
    end
    idle();
    repeat (30) step();
    log_en = 1'b0;
    seen = 0;
    foreach (bus_rd_log[k]) begin
      if (bus_rd_log[k] >= 5'd10 && bus_rd_log[k] <= 5'd12) begin
        check("bp_order", 64'(bus_rd_log[k]), 64'(10 + seen));
        seen++;
      end
    end
    check("bp_count", 64'(seen), 64'd3);

    // Rd = 0 is acknowledged but never broadcast
    ALUValid[1] = 1'b1; ALUResult[1] = 32'h1234; ALURd[1] = 5'd0;
    check("rd0_ready_before", 64'(ALUReady[1]), 64'd1);
    step();
    idle();
    check("rd0_ready_after", 64'(ALUReady[1]), 64'd1);
    repeat (3) begin
      step();
      check("rd0_no_write", 64'(RegWriteW), 64'd0);
    end

    // Flush with five buffered results and a push in the flush cycle
    for (int i = 0; i < 5; i++) begin
      ALUValid[i] = 1'b1; ALUResult[i] = $urandom; ALURd[i] = RD_W'(i + 1);
    end
    step();
    idle();
    Flush = 1'b1;
    ALUValid[4] = 1'b1; ALURd[4] = 5'd7;
    step();
    idle();
    check("flush_RegWriteW", 64'(RegWriteW), 64'd0);
    check("flush_ALUReady", 64'(ALUReady), 64'hFF);
    repeat (3) begin
      step();
      check("flush_quiet", 64'(RegWriteW), 64'd0);
    end
    ALUValid[6] = 1'b1; ALUResult[6] = 32'h66; ALURd[6] = 5'd6;
    step();
    idle();
    step();
    check("post_flush_RegWriteW", 64'(RegWriteW), 64'd1);
    check("post_flush_RdW", 64'(RdW), 64'd6);
    check("post_flush_ResultW", 64'(ResultW), 64'h66);

    // Asynchronous reset mid-stream
    for (int i = 0; i < NU; i++) begin
      ALUResult[i] = $urandom | 32'h1; ALURd[i] = RD_W'(i + 1);
    end
    ALUValid = '1;
    step();
    idle();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_RegWriteW", 64'(RegWriteW), 64'd0);
    check("areset_ResultW", 64'(ResultW), 64'd0);
    check("areset_RdW", 64'(RdW), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      step();
      check("areset_no_stale", 64'(RegWriteW), 64'd0);
    end
    check("areset_ALUReady", 64'(ALUReady), 64'hFF);

    // Randomized traffic at several load levels, with occasional flushes
    for (int phase = 0; phase < 3; phase++) begin
      repeat (600) begin
        case (phase)
          0:       ALUValid = NU'($urandom);
          1:       ALUValid = NU'($urandom & $urandom & $urandom);
          default: ALUValid = NU'($urandom | $urandom);
        endcase
        for (int i = 0; i < NU; i++) begin
          ALUResult[i] = $urandom;
          ALURd[i] = RD_W'($urandom_range(0, 31));
        end
        Flush = ($urandom_range(0, 63) == 0);
        step();
      end
    end
    idle();
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
